thread_fetch: RTL
=================

# thread_fetch

Round-robin multithreaded instruction-fetch stage for the barrel RISC-V core. It holds one program counter per hardware thread and picks one enabled thread per cycle. It drives that thread's PC as the byte address into the combinational, big-endian instruction memory and registers the returned word, PC and thread ID into the IF/ID pipeline register. It sits directly upstream of the instruction memory and feeds decode.

## Interface
- n, 32: address/instruction width
- THREADS, 4: hardware thread count (power of 2, ≥2)
- Psize, 512: instruction memory size in bytes (multiple of 4)
- RESET_STRIDE, 128: thread t resets to PC = t*RESET_STRIDE (multiple of 4, THREADS*RESET_STRIDE ≤ Psize)
- TW = $clog2(THREADS), derived localparam

Ports:
- clk  in  1  single clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- thread_en  in  THREADS  bit t=1: thread t eligible for fetch
- stall  in  1  hold IF/ID register and all PCs
- redirect_valid  in  1  branch/jump resolved for a thread
- redirect_tid  in  TW  thread being redirected
- redirect_pc  in  n  new PC; bits [1:0] ignored (forced 0)
- imem_addr  out  n  byte address to instruction memory
- imem_data  in  n  instruction word returned combinationally
- if_valid  out  1  IF/ID entry valid
- if_instr  out  n  fetched instruction
- if_pc  out  n  PC of if_instr
- if_tid  out  TW  thread of if_instr

## Operation
- State: pc[0..THREADS-1] (n bits each), last (TW bits, last selected thread), and the IF/ID registers.
- Reset (nrst=0, async): pc[t]=t*RESET_STRIDE; last=THREADS-1; if_valid=0; if_instr=0; if_pc=0; if_tid=0.
- Selection (comb): sel = first enabled thread scanning last+1, last+2, … modulo THREADS. any_en = |thread_en. If last is the only enabled thread, sel = last.
- imem_addr = pc[sel] when any_en, else 0.
- Next-PC arithmetic: inc = pc[sel]+4; if inc ≥ Psize, inc = 0 (wrap within memory).
- Clock edge, stall=0, any_en=1: if_instr←imem_data; if_pc←pc[sel]; if_tid←sel; if_valid←1; pc[sel]←inc; last←sel.
- Clock edge, stall=0, any_en=0: if_valid←0; other IF/ID fields, PCs and last unchanged.
- Clock edge, stall=1: IF/ID, last and non-redirected PCs held.
- Redirect (applied regardless of stall): pc[redirect_tid]←{redirect_pc[n-1:2],2'b00}. This overrides the increment when redirect_tid==sel.
- Squash: with stall=0, if redirect_tid==sel, the new entry is written with if_valid←0 (wrong-path fetch); last still advances to sel. With stall=1, if if_valid=1 and if_tid==redirect_tid, if_valid←0.
- Disabled thread: its PC is frozen; it resumes from that PC when re-enabled.

## Timing
- Address-to-IF/ID latency: 1 cycle. imem_addr is combinational from pc, last and thread_en; imem_data is captured at the next rising edge.
- Throughput: one fetch per cycle when not stalled. With k threads enabled, each gets every k-th slot.
- Redirect takes effect at the edge where redirect_valid=1. The redirected thread's next fetch uses redirect_pc.
- stall and redirect in the same cycle: PC update happens and the IF/ID squash rule for stall=1 applies.
- No combinational path from redirect_* or stall to imem_addr.

## Test plan
- Reset release, thread_en=4'b1111, stall=0 -> if_tid/if_pc sequence 0/0, 1/128, 2/256, 3/384, 0/4, 1/132. if_instr equals the memory word at each if_pc; if_valid=1 from the first edge.
- thread_en=4'b0101 -> tids alternate 0,2,0,2 with PCs +4 per visit. thread_en=0 for 3 cycles -> if_valid=0 and PCs unchanged. Re-enable -> resume at the frozen PCs.
- stall=1 for 2 cycles mid-stream -> if_* and imem_addr stable, no PC advances. Release -> sequence continues without skip or duplicate.
- redirect_valid=1, redirect_tid=sel=1, redirect_pc=0x43 -> IF/ID written with if_valid=0. Thread 1's next fetch has if_pc=0x40. Other threads unaffected.
- Set pc[3]=508 (via redirect), Psize=512 -> thread 3 fetches 508, then 0.
- Assert nrst=0 asynchronously mid-cycle during a stalled redirect -> outputs immediately take reset values. First post-reset fetch is tid 0, PC 0.

Source files
------------

// File: rtl/thread_fetch_if.sv
// Fetch-stage bundle: thread control and redirect inputs, the instruction memory
// port, and the IF/ID register outputs toward decode.
interface thread_fetch_if #(
  parameter int n       = 32,
  parameter int THREADS = 4
);
  localparam int TW = $clog2(THREADS);

  // Handshake: there is no ready. if_valid qualifies if_instr/if_pc/if_tid each
  // cycle. stall is the only backpressure and holds the entry in place. A
  // redirect is accepted on every edge where redirect_valid=1.
  logic [THREADS-1:0] thread_en;
  logic               stall;
  logic               redirect_valid;
  logic [TW-1:0]      redirect_tid;
  logic [n-1:0]       redirect_pc;
  logic [n-1:0]       imem_addr;
  logic [n-1:0]       imem_data;
  logic               if_valid;
  logic [n-1:0]       if_instr;
  logic [n-1:0]       if_pc;
  logic [TW-1:0]      if_tid;

  modport master (
    input  thread_en, stall, redirect_valid, redirect_tid, redirect_pc, imem_data,
    output imem_addr, if_valid, if_instr, if_pc, if_tid
  );

  modport slave (
    output thread_en, stall, redirect_valid, redirect_tid, redirect_pc, imem_data,
    input  imem_addr, if_valid, if_instr, if_pc, if_tid
  );
endinterface

// File: rtl/thread_fetch.sv
// Round-robin multithreaded instruction fetch: one PC per thread, one fetch per
// cycle from a combinational big-endian instruction memory into the IF/ID register.
module thread_fetch #(
  parameter int n            = 32,
  parameter int THREADS      = 4,
  parameter int Psize        = 512,
  parameter int RESET_STRIDE = 128
) (
  input  logic          clk,
  input  logic          nrst,
  thread_fetch_if.master bus
);
  localparam int TW = $clog2(THREADS);

  logic [n-1:0]  pc_q [THREADS];
  logic [n-1:0]  pc_d [THREADS];
  logic [TW-1:0] last_q, last_d;
  logic          if_valid_q, if_valid_d;
  logic [n-1:0]  if_instr_q, if_instr_d;
  logic [n-1:0]  if_pc_q, if_pc_d;
  logic [TW-1:0] if_tid_q, if_tid_d;

  logic [TW-1:0] sel;
  logic [TW-1:0] idx;
  logic          found;
  logic          any_en;
  logic [n-1:0]  sel_pc;
  logic [n-1:0]  inc;
  logic          squash_new;

  // Scan starts one past the last winner; the final step wraps back onto last
  // itself so a lone enabled thread keeps being selected.
  always_comb begin
    sel   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int i = 1; i <= THREADS; i++) begin
      idx = last_q + TW'(i);
      if (!found && bus.thread_en[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign any_en        = |bus.thread_en;
  assign sel_pc        = pc_q[sel];
  assign bus.imem_addr = any_en ? sel_pc : '0;

  always_comb begin
    inc = sel_pc + n'(4);
    if (inc >= n'(Psize)) inc = '0;
  end

  assign squash_new = bus.redirect_valid && (bus.redirect_tid == sel);

  always_comb begin
    pc_d       = pc_q;
    last_d     = last_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_tid_d   = if_tid_q;
    if (!bus.stall) begin
      if (any_en) begin
        if_instr_d = bus.imem_data;
        if_pc_d    = sel_pc;
        if_tid_d   = sel;
        if_valid_d = !squash_new;
        pc_d[sel]  = inc;
        last_d     = sel;
      end else begin
        if_valid_d = 1'b0;
      end
    end else if (bus.redirect_valid && if_valid_q && (if_tid_q == bus.redirect_tid)) begin
      if_valid_d = 1'b0;
    end
    // Redirect wins over the increment of the same thread.
    if (bus.redirect_valid) pc_d[bus.redirect_tid] = bus.redirect_pc & ~n'(3);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int t = 0; t < THREADS; t++) pc_q[t] <= n'(t * RESET_STRIDE);
      last_q     <= TW'(THREADS - 1);
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_tid_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      last_q     <= last_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_tid_q   <= if_tid_d;
    end
  end

  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_tid   = if_tid_q;
endmodule
